// File: rtl/lvds_tx_link_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : lvds_tx_link_ctrl                                          |
// | Brief    : LVDS serializer bring-up sequencer and video timing source.|
// |            Optional colour-bar generator under LVDS_TX_TEST_PATTERN_EN|
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module lvds_tx_link_ctrl #(
    parameter int H_ACTIVE     = 1024,
    parameter int H_FP         = 24,
    parameter int H_SYNC       = 136,
    parameter int H_BP         = 160,
    parameter int V_ACTIVE     = 768,
    parameter int V_FP         = 3,
    parameter int V_SYNC       = 6,
    parameter int V_BP         = 29,
    parameter bit HS_POL       = 1'b0,
    parameter bit VS_POL       = 1'b0,
    parameter int LOCK_CYCLES  = 1024,
    parameter int BLANK_FRAMES = 2
) (
    input  logic       I_pix_clk,
    input  logic       I_rst,
    input  logic       I_pll_lock,
    input  logic       I_enable,
    input  logic [7:0] I_data_r,
    input  logic [7:0] I_data_g,
    input  logic [7:0] I_data_b,
`ifdef LVDS_TX_TEST_PATTERN_EN
    input  logic       I_pattern_sel,
`endif
    output logic       O_pix_req,
    output logic       O_vs,
    output logic       O_hs,
    output logic       O_de,
    output logic [7:0] O_data_r,
    output logic [7:0] O_data_g,
    output logic [7:0] O_data_b,
    output logic       O_tx_rst,
    output logic       O_link_up
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int LOCK_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int FRAME_W = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;

    localparam logic [11:0]        c_h_last     = 12'(H_TOTAL - 1);
    localparam logic [11:0]        c_v_last     = 12'(V_TOTAL - 1);
    localparam logic [11:0]        c_h_active   = 12'(H_ACTIVE);
    localparam logic [11:0]        c_v_active   = 12'(V_ACTIVE);
    localparam logic [11:0]        c_hs_start   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0]        c_hs_end     = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0]        c_vs_start   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0]        c_vs_end     = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [LOCK_W-1:0]  c_lock_last  = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [FRAME_W-1:0] c_frame_last = FRAME_W'(BLANK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOCK_WAIT = 2'd1,
        ST_BLANK     = 2'd2,
        ST_VIDEO     = 2'd3
    } state_t;

    state_t             r_state;
    logic [11:0]        r_h_cnt;
    logic [11:0]        r_v_cnt;
    logic [LOCK_W-1:0]  r_lock_cnt;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic               r_stop_req;
    logic               r_hs;
    logic               r_vs;
    logic               r_de;
    logic [7:0]         r_data_r;
    logic [7:0]         r_data_g;
    logic [7:0]         r_data_b;
    logic               r_tx_rst;
    logic               r_link_up;

    logic w_running;
    logic w_lock_loss;
    logic w_h_last;
    logic w_frame_wrap;
    logic w_active;
    logic w_active_video;
    logic w_hs_act;
    logic w_vs_act;
    logic w_pix_req;

    assign w_running      = (r_state == ST_BLANK) || (r_state == ST_VIDEO);
    assign w_lock_loss    = w_running && !I_pll_lock;
    assign w_h_last       = (r_h_cnt == c_h_last);
    assign w_frame_wrap   = w_h_last && (r_v_cnt == c_v_last);
    assign w_active       = (r_h_cnt < c_h_active) && (r_v_cnt < c_v_active);
    assign w_hs_act       = (r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end);
    assign w_vs_act       = (r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end);
    // A lock drop this cycle already cancels the pixel, so no upstream data is consumed.
    assign w_active_video = !I_rst && (r_state == ST_VIDEO) && w_active && !w_lock_loss;

`ifdef LVDS_TX_TEST_PATTERN_EN
    localparam logic [11:0] c_bar_w = 12'(H_ACTIVE / 8);

    logic [11:0] w_bar_quot;
    logic [2:0]  w_bar_idx;

    assign w_bar_quot = r_h_cnt / c_bar_w;
    assign w_bar_idx  = (w_bar_quot >= 12'd7) ? 3'd7 : w_bar_quot[2:0];
    assign w_pix_req  = w_active_video && !I_pattern_sel;
`else
    assign w_pix_req  = w_active_video;
`endif

    always_ff @(posedge I_pix_clk) begin
        if (I_rst) begin
            r_state     <= ST_IDLE;
            r_h_cnt     <= 12'd0;
            r_v_cnt     <= 12'd0;
            r_lock_cnt  <= '0;
            r_frame_cnt <= '0;
            r_stop_req  <= 1'b0;
            r_hs        <= ~HS_POL;
            r_vs        <= ~VS_POL;
            r_de        <= 1'b0;
            r_data_r    <= 8'h00;
            r_data_g    <= 8'h00;
            r_data_b    <= 8'h00;
            r_tx_rst    <= 1'b1;
            r_link_up   <= 1'b0;
        end else begin
            r_hs <= (w_running && w_hs_act) ? HS_POL : ~HS_POL;
            r_vs <= (w_running && w_vs_act) ? VS_POL : ~VS_POL;
            r_de <= w_active_video;
`ifdef LVDS_TX_TEST_PATTERN_EN
            if (w_active_video && I_pattern_sel) begin
                r_data_r <= {8{~w_bar_idx[1]}};
                r_data_g <= {8{~w_bar_idx[2]}};
                r_data_b <= {8{~w_bar_idx[0]}};
            end else
`endif
            if (w_pix_req) begin
                r_data_r <= I_data_r;
                r_data_g <= I_data_g;
                r_data_b <= I_data_b;
            end else begin
                r_data_r <= 8'h00;
                r_data_g <= 8'h00;
                r_data_b <= 8'h00;
            end

            case (r_state)
                ST_IDLE: begin
                    r_h_cnt     <= 12'd0;
                    r_v_cnt     <= 12'd0;
                    r_lock_cnt  <= '0;
                    r_frame_cnt <= '0;
                    r_stop_req  <= 1'b0;
                    r_tx_rst    <= 1'b1;
                    r_link_up   <= 1'b0;
                    if (I_enable) begin
                        r_state <= ST_LOCK_WAIT;
                    end
                end
                ST_LOCK_WAIT: begin
                    r_h_cnt     <= 12'd0;
                    r_v_cnt     <= 12'd0;
                    r_frame_cnt <= '0;
                    r_stop_req  <= 1'b0;
                    r_link_up   <= 1'b0;
                    r_tx_rst    <= 1'b1;
                    if (!I_enable) begin
                        r_state    <= ST_IDLE;
                        r_lock_cnt <= '0;
                    end else if (!I_pll_lock) begin
                        r_lock_cnt <= '0;
                    end else if (r_lock_cnt == c_lock_last) begin
                        r_state    <= ST_BLANK;
                        r_lock_cnt <= '0;
                        r_tx_rst   <= 1'b0;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + 1'b1;
                    end
                end
                ST_BLANK, ST_VIDEO: begin
                    if (w_lock_loss) begin
                        r_state     <= ST_LOCK_WAIT;
                        r_h_cnt     <= 12'd0;
                        r_v_cnt     <= 12'd0;
                        r_lock_cnt  <= '0;
                        r_frame_cnt <= '0;
                        r_stop_req  <= 1'b0;
                        r_tx_rst    <= 1'b1;
                        r_link_up   <= 1'b0;
                    end else begin
                        if (w_h_last) begin
                            r_h_cnt <= 12'd0;
                            r_v_cnt <= (r_v_cnt == c_v_last) ? 12'd0 : r_v_cnt + 12'd1;
                        end else begin
                            r_h_cnt <= r_h_cnt + 12'd1;
                        end
                        // A disable request is remembered so the frame still runs to its end.
                        if (!I_enable) begin
                            r_stop_req <= 1'b1;
                        end
                        if (w_frame_wrap) begin
                            if (r_stop_req || !I_enable) begin
                                r_state     <= ST_IDLE;
                                r_stop_req  <= 1'b0;
                                r_frame_cnt <= '0;
                                r_tx_rst    <= 1'b1;
                                r_link_up   <= 1'b0;
                            end else if (r_state == ST_BLANK) begin
                                if (r_frame_cnt == c_frame_last) begin
                                    r_state     <= ST_VIDEO;
                                    r_frame_cnt <= '0;
                                    r_link_up   <= 1'b1;
                                end else begin
                                    r_frame_cnt <= r_frame_cnt + 1'b1;
                                end
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign O_pix_req = w_pix_req;
    assign O_hs      = r_hs;
    assign O_vs      = r_vs;
    assign O_de      = r_de;
    assign O_data_r  = r_data_r;
    assign O_data_g  = r_data_g;
    assign O_data_b  = r_data_b;
    assign O_tx_rst  = r_tx_rst;
    assign O_link_up = r_link_up;

endmodule
`default_nettype wire

// File: tb/tb_lvds_tx_link_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_lvds_tx_link_ctrl                                       |
// | Brief    : Self-checking bench for lvds_tx_link_ctrl (small timing).  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_lvds_tx_link_ctrl;

    localparam int HA = 8, HFP = 2, HSY = 2, HBP = 2;
    localparam int VA = 4, VFP = 1, VSY = 1, VBP = 1;
    localparam int LOCKN = 4, BLANKN = 1;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FT = HT * VT;
    localparam bit HP = 1'b0, VP = 1'b0;
    localparam int M_IDLE = 0, M_LOCK = 1, M_BLANK = 2, M_VIDEO = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1, en = 1'b0, lock = 1'b0, psel = 1'b0;
    logic [7:0] dr = 8'h00, dg = 8'h00, db = 8'h00;
    logic       pix_req, o_vs, o_hs, o_de, tx_rst, link_up;
    logic [7:0] o_r, o_g, o_b;

    lvds_tx_link_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(HP), .VS_POL(VP), .LOCK_CYCLES(LOCKN), .BLANK_FRAMES(BLANKN)
    ) dut (
        .I_pix_clk(clk), .I_rst(rst), .I_pll_lock(lock), .I_enable(en),
        .I_data_r(dr), .I_data_g(dg), .I_data_b(db),
`ifdef LVDS_TX_TEST_PATTERN_EN
        .I_pattern_sel(psel),
`endif
        .O_pix_req(pix_req), .O_vs(o_vs), .O_hs(o_hs), .O_de(o_de),
        .O_data_r(o_r), .O_data_g(o_g), .O_data_b(o_b),
        .O_tx_rst(tx_rst), .O_link_up(link_up)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: link phase plus a linear pixel position within the frame.
    int          m_state = M_IDLE, m_pos = 0, m_lock_run = 0, m_frames = 0;
    bit          m_stop = 1'b0;
    logic        e_hs = 1'b1, e_vs = 1'b1, e_de = 1'b0, e_tx = 1'b1, e_link = 1'b0;
    logic [23:0] e_data = 24'h0;
    logic [23:0] bars [8];

    typedef struct {
        logic        rst, en, lock;
        logic [23:0] data;
        int          n;
        logic        tx, link, de, hs, vs;
        logic [23:0] dout;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic e, input logic l,
                              input logic [23:0] d, input bit vid, input int h, input int v);
        bit running;
        if (r) begin
            m_state = M_IDLE; m_pos = 0; m_lock_run = 0; m_frames = 0; m_stop = 0;
            e_hs = ~HP; e_vs = ~VP; e_de = 0; e_data = 0; e_tx = 1; e_link = 0;
            return;
        end
        running = (m_state == M_BLANK) || (m_state == M_VIDEO);
        e_hs   = (running && h >= HA + HFP && h < HA + HFP + HSY) ? HP : ~HP;
        e_vs   = (running && v >= VA + VFP && v < VA + VFP + VSY) ? VP : ~VP;
        e_de   = vid;
        e_data = vid ? (psel ? bars[h / (HA / 8)] : d) : 24'h0;
        case (m_state)
            M_IDLE: if (e) begin m_state = M_LOCK; m_lock_run = 0; end
            M_LOCK: begin
                if (!e) m_state = M_IDLE;
                else if (!l) m_lock_run = 0;
                else begin
                    m_lock_run++;
                    if (m_lock_run == LOCKN) begin
                        m_state = M_BLANK; m_pos = 0; m_frames = 0; m_stop = 0;
                    end
                end
            end
            default: begin
                if (!l) begin
                    m_state = M_LOCK; m_lock_run = 0; m_pos = 0; m_stop = 0;
                end else begin
                    if (!e) m_stop = 1;
                    if (m_pos == FT - 1) begin
                        m_pos = 0;
                        if (m_stop) begin
                            m_state = M_IDLE; m_stop = 0;
                        end else if (m_state == M_BLANK) begin
                            m_frames++;
                            if (m_frames == BLANKN) m_state = M_VIDEO;
                        end
                    end else begin
                        m_pos++;
                    end
                end
            end
        endcase
        e_tx   = (m_state == M_IDLE) || (m_state == M_LOCK);
        e_link = (m_state == M_VIDEO);
    endtask

    // One clock: drive, check combinational request mid-cycle, check registers after the edge.
    task automatic step(input logic r, input logic e, input logic l, input logic [23:0] d);
        int h, v;
        bit vid;
        rst = r; en = e; lock = l; {dr, dg, db} = d;
        @(negedge clk);
        h   = m_pos % HT;
        v   = m_pos / HT;
        vid = !r && (m_state == M_VIDEO) && l && (h < HA) && (v < VA);
        chk("pix_req", {31'd0, pix_req}, {31'd0, vid && !psel});
        model_edge(r, e, l, d, vid, h, v);
        @(posedge clk);
        #1;
        chk("hs", {31'd0, o_hs}, {31'd0, e_hs});
        chk("vs", {31'd0, o_vs}, {31'd0, e_vs});
        chk("de", {31'd0, o_de}, {31'd0, e_de});
        chk("data", {8'd0, o_r, o_g, o_b}, {8'd0, e_data});
        chk("tx_rst", {31'd0, tx_rst}, {31'd0, e_tx});
        chk("link_up", {31'd0, link_up}, {31'd0, e_link});
    endtask

    task automatic run(input int n, input logic r, input logic e, input logic l);
        for (int k = 0; k < n; k++) step(r, e, l, 24'($urandom));
    endtask

    initial begin
        logic        r_en;
        logic        r_rst, r_lock;
        logic [23:0] r_pix;

        bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
        bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;

        //             rst   en    lock  data        n   tx    link  de    hs    vs    dout
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 24'h112233,  3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'h0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 24'h112233,  1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'h0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 24'h112233,  3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'h0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 24'h112233,  1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 24'h112233, 97, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 24'h112233,  1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 24'h112233,  1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 24'h112233};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 24'h112233, 10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 24'h112233,  1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 24'h112233,  1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 24'h112233, 58, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 24'h112233,  1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 24'h112233,  1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'h0};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 24'h112233,  3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h0};

        @(posedge clk);
        #1;
        for (int i = 0; i < 14; i++) begin
            for (int k = 0; k < tbl[i].n; k++) step(tbl[i].rst, tbl[i].en, tbl[i].lock, tbl[i].data);
            chk($sformatf("vec%0d_tx_rst", i), {31'd0, tx_rst}, {31'd0, tbl[i].tx});
            chk($sformatf("vec%0d_link_up", i), {31'd0, link_up}, {31'd0, tbl[i].link});
            chk($sformatf("vec%0d_de", i), {31'd0, o_de}, {31'd0, tbl[i].de});
            chk($sformatf("vec%0d_hs", i), {31'd0, o_hs}, {31'd0, tbl[i].hs});
            chk($sformatf("vec%0d_vs", i), {31'd0, o_vs}, {31'd0, tbl[i].vs});
            chk($sformatf("vec%0d_data", i), {8'd0, o_r, o_g, o_b}, {8'd0, tbl[i].dout});
        end

        // Interrupted lock run must restart the consecutive count.
        run(2, 1'b1, 1'b0, 1'b0);
        run(1, 1'b0, 1'b1, 1'b1);
        run(3, 1'b0, 1'b1, 1'b1);
        run(1, 1'b0, 1'b1, 1'b0);
        run(3, 1'b0, 1'b1, 1'b1);
        chk("lock_glitch_no_blank", {31'd0, tx_rst}, 32'd1);
        run(1, 1'b0, 1'b1, 1'b1);
        chk("lock_glitch_blank", {31'd0, tx_rst}, 32'd0);

        // Disable mid-frame: the frame completes before returning to idle.
        run(FT, 1'b0, 1'b1, 1'b1);
        chk("video_entry", {31'd0, link_up}, 32'd1);
        run(HT, 1'b0, 1'b1, 1'b1);
        run(FT - HT - 1, 1'b0, 1'b0, 1'b1);
        chk("stop_frame_runs", {31'd0, link_up}, 32'd1);
        run(1, 1'b0, 1'b0, 1'b1);
        chk("stop_idle_link", {31'd0, link_up}, 32'd0);
        chk("stop_idle_txrst", {31'd0, tx_rst}, 32'd1);
        chk("stop_idle_de", {31'd0, o_de}, 32'd0);
        run(3, 1'b0, 1'b0, 1'b1);
        chk("stop_idle_hold", {31'd0, tx_rst}, 32'd1);

        // Random traffic against the model.
        r_en = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            if (r_en) r_en = ($urandom_range(0, 499) != 0);
            else      r_en = ($urandom_range(0, 49) == 0);
            r_rst  = ($urandom_range(0, 1999) == 0);
            r_lock = ($urandom_range(0, 299) != 0);
            r_pix  = 24'($urandom);
            step(r_rst, r_en, r_lock, r_pix);
        end

`ifdef LVDS_TX_TEST_PATTERN_EN
        run(2, 1'b1, 1'b0, 1'b0);
        run(1 + LOCKN + FT, 1'b0, 1'b1, 1'b1);
        psel = 1'b1;
        for (int px = 0; px < 8; px++) begin
            step(1'b0, 1'b1, 1'b1, 24'h112233);
            chk($sformatf("bar%0d", px), {8'd0, o_r, o_g, o_b}, {8'd0, bars[px]});
        end
        run(HT - 8, 1'b0, 1'b1, 1'b1);
        psel = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lvds_tx_link_ctrl.md
LVDS_TX_LINK_CTRL -- requirements
Module: lvds_tx_link_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1024, active pixels per line.
REQ-002 SHALL have parameters H_FP / H_SYNC / H_BP, defaults 24 / 136 / 160, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 768, active lines per frame.
REQ-004 SHALL have parameters V_FP / V_SYNC / V_BP, defaults 3 / 6 / 29, vertical porch and sync widths in lines.
REQ-005 SHALL have parameters HS_POL / VS_POL, default 0 / 0, sync active level.
REQ-006 SHALL have parameter LOCK_CYCLES, default 1024, consecutive lock cycles required before link start.
REQ-007 SHALL have parameter BLANK_FRAMES, default 2, blank frames sent before video.
REQ-008 SHALL have ports:
- I_pix_clk  in  1  pixel clock, the only clock.
- I_rst  in  1  synchronous active-high reset.
- I_pll_lock  in  1  serializer PLL lock.
- I_enable  in  1  link enable request.
- I_data_r / I_data_g / I_data_b  in  8 each  upstream pixel.
- O_pix_req  out  1  pixel request.
- O_vs / O_hs / O_de  out  1 each  timing to serializer.
- O_data_r / O_data_g / O_data_b  out  8 each  pixel to serializer.
- O_tx_rst  out  1  serializer reset, active high.
- O_link_up  out  1  high in VIDEO.

Function
REQ-009 SHALL implement states IDLE, LOCK_WAIT, BLANK, VIDEO.
REQ-010 SHALL hold 12-bit h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1), where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; h_cnt wraps to 0 and increments v_cnt; v_cnt wraps to 0 at V_TOTAL-1 with h_cnt=H_TOTAL-1.
REQ-011 SHALL keep counters at 0 in IDLE and LOCK_WAIT, and run them in BLANK and VIDEO.
REQ-012 IDLE->LOCK_WAIT when I_enable=1.
REQ-013 LOCK_WAIT SHALL count consecutive I_pll_lock=1 cycles, clear the count on any 0, and go to BLANK on the cycle the count reaches LOCK_CYCLES.
REQ-014 BLANK SHALL count frame wraps and go to VIDEO at the wrap completing BLANK_FRAMES frames.
REQ-015 SHALL go to LOCK_WAIT from BLANK or VIDEO on I_pll_lock=0 in the same cycle, with counters and lock count zeroed; this takes priority over I_enable.
REQ-016 With I_enable=0 in BLANK or VIDEO, SHALL finish the current frame and go to IDLE at the frame wrap; I_enable=0 in LOCK_WAIT SHALL go to IDLE next cycle.
REQ-017 Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-018 HS active: H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
REQ-019 VS active: V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
REQ-020 O_pix_req SHALL be combinational: 1 iff state VIDEO, the counters are in the active region, and no lock loss occurs this cycle.
REQ-021 O_hs/O_vs/O_de/O_data_* SHALL be registered and reflect the previous cycle's counters and state, so O_de=1 exactly one cycle after O_pix_req=1.
REQ-022 I_data_* SHALL be sampled at the edge ending a cycle with O_pix_req=1; O_data_* SHALL be 0 whenever O_de=0.
REQ-023 O_hs/O_vs SHALL be driven at the inactive level in IDLE and LOCK_WAIT, and from the counters in BLANK and VIDEO; O_de SHALL be 0 in BLANK.
REQ-024 O_tx_rst SHALL be 1 in IDLE and LOCK_WAIT and 0 otherwise, registered; O_link_up SHALL be 1 iff state VIDEO, registered.

Reset
REQ-025 On I_rst=1 at the clock edge, SHALL enter IDLE and zero all counters; O_hs=~HS_POL, O_vs=~VS_POL, O_de=0, O_data_*=0, O_tx_rst=1, O_link_up=0; O_pix_req SHALL be 0 while in reset.
REQ-026 Reset mid-frame SHALL abort immediately, without frame completion.

Configuration
REQ-027 With LVDS_TX_TEST_PATTERN_EN defined, SHALL add input I_pattern_sel (1 bit); when I_pattern_sel=1, O_data_* SHALL carry 8 vertical colour bars, each H_ACTIVE/8 pixels wide, in the order white, yellow, cyan, green, magenta, red, blue, black (components 0xFF/0x00), and O_pix_req SHALL stay 0.
REQ-028 Without LVDS_TX_TEST_PATTERN_EN, the I_pattern_sel port and bar logic SHALL be absent.

Verification (H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1, LOCK_CYCLES=4, BLANK_FRAMES=1)
REQ-029 Set I_enable=1 and I_pll_lock=1 from reset release -> BLANK entered 4 cycles after LOCK_WAIT entry; VIDEO entered after 98 cycles (14x7); O_tx_rst falls on BLANK entry.
REQ-030 In VIDEO -> O_pix_req high for 8 cycles per line on 4 lines; O_de follows one cycle later; O_hs active 2 cycles per line; O_vs active for 14 cycles; I_data=0x112233 -> O_data=0x112233.
REQ-031 Drop lock for 1 cycle mid-VIDEO -> LOCK_WAIT next cycle, O_de=0, O_tx_rst=1, O_link_up=0; the full 4-cycle lock sequence and 1 blank frame repeat.
REQ-032 Lock toggling 1,1,1,0,1 in LOCK_WAIT -> no BLANK entry until 4 consecutive lock cycles.
REQ-033 Drop I_enable at v_cnt=1 -> frame completes, IDLE entered at wrap, outputs blank.
REQ-034 With macro defined and I_pattern_sel=1 -> O_data per pixel FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000; O_pix_req=0.
